// File: rtl/keys_input_pio.sv
// Purpose : Avalon-MM input PIO for board keys/switches with per-bit sync, debounce and edge capture.
// Latency : readdata is combinational (zero wait); a clean pin change reaches DATA at edge k+1+DEBOUNCE_CYCLES.
// Backpress: none; the slave always accepts reads and writes in a single cycle.
//
// Ports:
//   clk, reset_n        system clock, asynchronous active-low reset
//   address[1:0]        0 DATA (RO), 1 RAW (RO), 2 IRQ_MASK (RW), 3 EDGE_CAPTURE (W1C)
//   chipselect, write_n write strobe qualification (write when chipselect && !write_n)
//   writedata[31:0]     write data, bits [WIDTH-1:0] used
//   in_port[WIDTH-1:0]  raw asynchronous pins
//   readdata[31:0]      register read data, upper bits zero
//   irq                 level interrupt = |(edge_capture & irq_mask)
module keys_input_pio #(
    parameter int               WIDTH           = 8,
    parameter int               DEBOUNCE_CYCLES = 50000,
    parameter logic [WIDTH-1:0] RESET_STATE     = {WIDTH{1'b1}},
    parameter int               EDGE_TYPE       = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    // Counter only has to reach DEBOUNCE_CYCLES-1, so it never wraps.
    localparam int            CW      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_stable;
    logic [WIDTH-1:0] r_irq_mask;
    logic [WIDTH-1:0] r_edge_capture;

    logic [WIDTH-1:0] w_done;     // bit finished debouncing this cycle, stable takes sync2
    logic [WIDTH-1:0] w_set;      // qualifying edge events
    logic [WIDTH-1:0] w_clr;      // W1C clear bits
    logic             w_wr_en;
    logic             w_unused_wdata;

    assign w_wr_en        = chipselect & ~write_n;
    assign w_unused_wdata = ^writedata;

    // Two-flop synchronizer; reset to RESET_STATE so idle keys show no edge after reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= RESET_STATE;
            r_sync2 <= RESET_STATE;
        end else begin
            r_sync1 <= in_port;
            r_sync2 <= r_sync1;
        end
    end

    // Per-bit debounce counter. Any return of sync2 to the stable value clears
    // the count, so only an uninterrupted run of DEBOUNCE_CYCLES cycles is accepted.
    genvar g;
    generate
        for (g = 0; g < WIDTH; g++) begin : g_db
            logic [CW-1:0] r_cnt;

            assign w_done[g] = (r_sync2[g] != r_stable[g]) && (r_cnt == CNT_MAX);

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_cnt <= '0;
                end else if ((r_sync2[g] == r_stable[g]) || w_done[g]) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    endgenerate

    // Direction of an event is the new stable value, which is sync2 on the done cycle.
    always_comb begin
        w_set = w_done;
        if (EDGE_TYPE == 0) begin
            w_set = w_done & r_sync2;
        end else if (EDGE_TYPE == 1) begin
            w_set = w_done & ~r_sync2;
        end
    end

    assign w_clr = (w_wr_en && (address == 2'd3)) ? writedata[WIDTH-1:0] : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stable       <= RESET_STATE;
            r_irq_mask     <= '0;
            r_edge_capture <= '0;
        end else begin
            r_stable <= (r_stable & ~w_done) | (r_sync2 & w_done);
            if (w_wr_en && (address == 2'd2)) begin
                r_irq_mask <= writedata[WIDTH-1:0];
            end
            // Set is applied after clear so a same-cycle event is never lost.
            r_edge_capture <= (r_edge_capture & ~w_clr) | w_set;
        end
    end

    // Combinational OR of registered state only: no glitch path from in_port.
    assign irq = |(r_edge_capture & r_irq_mask);

    always_comb begin
        readdata = '0;
        case (address)
            2'd0:    readdata[WIDTH-1:0] = r_stable;
            2'd1:    readdata[WIDTH-1:0] = r_sync2;
            2'd2:    readdata[WIDTH-1:0] = r_irq_mask;
            2'd3:    readdata[WIDTH-1:0] = r_edge_capture;
            default: readdata = '0;
        endcase
    end

endmodule
